// File: rtl/arf_rat_pkg.sv
// Shared definitions for the architectural register file and rename alias table.
// Checkpoint logic reuses rat_entry_t to snapshot the rename state.
package arf_rat_pkg;

  localparam int ARF_N_ENTRIES  = 32;
  localparam int ROB_N_ENTRIES  = 16;
  localparam int REG_DATA_WIDTH = 32;

  localparam int ARF_ID_W = $clog2(ARF_N_ENTRIES);
  localparam int ROB_ID_W = $clog2(ROB_N_ENTRIES);

  typedef logic [ARF_ID_W-1:0]       arf_id_t;
  typedef logic [ROB_ID_W-1:0]       rob_id_t;
  typedef logic [REG_DATA_WIDTH-1:0] reg_data_t;

  typedef struct packed {
    logic    renamed;
    rob_id_t tag;
  } rat_entry_t;

endpackage

// File: rtl/arf_rat_entry.sv
// One architectural register: committed data plus its rename state.
// The top decodes the register id; this block only sees per-entry hit strobes.
module arf_rat_entry
  import arf_rat_pkg::*;
(
  input  logic       clk,
  input  logic       rst_aL,
  input  logic       dispatch_hit,
  input  rob_id_t    dispatch_rob_id,
  input  logic       retire_hit,
  input  rob_id_t    retire_rob_id,
  input  reg_data_t  retire_reg_data,
  input  logic       flush,
  output reg_data_t  data,
  output rat_entry_t entry
);

  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      data  <= '0;
      entry <= '0;
    end else begin
      if (retire_hit) begin
        data <= retire_reg_data;
      end
      // Priority: flush kills everything, then a new writer, then the retiring one
      // (which only releases the mapping if no younger writer took over).
      if (flush) begin
        entry.renamed <= 1'b0;
      end else if (dispatch_hit) begin
        entry.renamed <= 1'b1;
        entry.tag     <= dispatch_rob_id;
      end else if (retire_hit && (entry.tag == retire_rob_id)) begin
        entry.renamed <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/arf_rat.sv
// Architectural register file with rename alias table: per-register committed data
// and the ROB slot of the youngest in-flight writer, read combinationally.
module arf_rat
  import arf_rat_pkg::*;
#(
  parameter int ARF_N_ENTRIES  = arf_rat_pkg::ARF_N_ENTRIES,
  parameter int ROB_N_ENTRIES  = arf_rat_pkg::ROB_N_ENTRIES,
  parameter int REG_DATA_WIDTH = arf_rat_pkg::REG_DATA_WIDTH
) (
  input  logic      clk,
  input  logic      rst_aL,
  // dispatch_en is already the fired handshake (valid && ROB ready); a cycle with
  // dispatch_en=0 carries no allocation regardless of the other dispatch fields.
  input  logic      dispatch_en,
  input  logic      dispatch_dst_valid,
  input  arf_id_t   dispatch_dst_arf_id,
  input  rob_id_t   dispatch_rob_id,
  input  logic      retire,
  input  rob_id_t   retire_rob_id,
  input  arf_id_t   retire_arf_id,
  input  reg_data_t retire_reg_data,
  input  logic      flush,
  input  arf_id_t   src1_arf_id,
  input  arf_id_t   src2_arf_id,
  output logic      src1_renamed,
  output rob_id_t   src1_rob_id,
  output reg_data_t src1_reg_data,
  output logic      src2_renamed,
  output rob_id_t   src2_rob_id,
  output reg_data_t src2_reg_data
);

  typedef struct packed {
    logic      renamed;
    rob_id_t   rob_id;
    reg_data_t data;
  } rd_t;

  logic [$clog2(ROB_N_ENTRIES)-1:0] retire_tag;
  logic [REG_DATA_WIDTH-1:0]        retire_data;

  reg_data_t  data_q [ARF_N_ENTRIES];
  rat_entry_t ent_q  [ARF_N_ENTRIES];

  logic [ARF_N_ENTRIES-1:0] dispatch_hit;
  logic [ARF_N_ENTRIES-1:0] retire_hit;

  rd_t rd1;
  rd_t rd2;

  assign retire_tag  = retire_rob_id;
  assign retire_data = retire_reg_data;

  // x0 keeps an entry instance but never receives a hit, so it stays at reset value.
  for (genvar i = 0; i < ARF_N_ENTRIES; i++) begin : g_entry
    assign dispatch_hit[i] = (i != 0) && dispatch_en && dispatch_dst_valid &&
                             (dispatch_dst_arf_id == arf_id_t'(i));
    assign retire_hit[i]   = (i != 0) && retire && (retire_arf_id == arf_id_t'(i));

    arf_rat_entry u_entry (
      .clk             (clk),
      .rst_aL          (rst_aL),
      .dispatch_hit    (dispatch_hit[i]),
      .dispatch_rob_id (dispatch_rob_id),
      .retire_hit      (retire_hit[i]),
      .retire_rob_id   (retire_tag),
      .retire_reg_data (retire_data),
      .flush           (flush),
      .data            (data_q[i]),
      .entry           (ent_q[i])
    );
  end

  // Same-cycle retire of the current producer is forwarded; same-cycle dispatch is not.
  function automatic rd_t lookup(input arf_id_t id, input rat_entry_t ent,
                                 input reg_data_t data, input logic ret_v,
                                 input arf_id_t ret_id, input rob_id_t ret_tag,
                                 input reg_data_t ret_data);
    rd_t r;
    r.renamed = ent.renamed;
    r.rob_id  = ent.tag;
    r.data    = data;
    if (id == '0) begin
      r = '0;
    end else if (ret_v && (id == ret_id) && ent.renamed && (ent.tag == ret_tag)) begin
      r.renamed = 1'b0;
      r.data    = ret_data;
    end
    return r;
  endfunction

  always_comb begin
    rd1 = lookup(src1_arf_id, ent_q[src1_arf_id], data_q[src1_arf_id],
                 retire, retire_arf_id, retire_tag, retire_data);
    rd2 = lookup(src2_arf_id, ent_q[src2_arf_id], data_q[src2_arf_id],
                 retire, retire_arf_id, retire_tag, retire_data);
  end

  assign src1_renamed  = rd1.renamed;
  assign src1_rob_id   = rd1.rob_id;
  assign src1_reg_data = rd1.data;
  assign src2_renamed  = rd2.renamed;
  assign src2_rob_id   = rd2.rob_id;
  assign src2_reg_data = rd2.data;

endmodule

// File: tb/tb_arf_rat.sv
// Bench for arf_rat: table of per-cycle stimulus with expected lookup results,
// plus a hand-written asynchronous reset sequence.
module tb_arf_rat;
  import arf_rat_pkg::*;

  logic      clk = 1'b0;
  logic      rst_aL;
  logic      dispatch_en, dispatch_dst_valid;
  arf_id_t   dispatch_dst_arf_id;
  rob_id_t   dispatch_rob_id;
  logic      retire;
  rob_id_t   retire_rob_id;
  arf_id_t   retire_arf_id;
  reg_data_t retire_reg_data;
  logic      flush;
  arf_id_t   src1_arf_id, src2_arf_id;
  logic      src1_renamed, src2_renamed;
  rob_id_t   src1_rob_id, src2_rob_id;
  reg_data_t src1_reg_data, src2_reg_data;

  arf_rat dut (
    .clk                 (clk),
    .rst_aL              (rst_aL),
    .dispatch_en         (dispatch_en),
    .dispatch_dst_valid  (dispatch_dst_valid),
    .dispatch_dst_arf_id (dispatch_dst_arf_id),
    .dispatch_rob_id     (dispatch_rob_id),
    .retire              (retire),
    .retire_rob_id       (retire_rob_id),
    .retire_arf_id       (retire_arf_id),
    .retire_reg_data     (retire_reg_data),
    .flush               (flush),
    .src1_arf_id         (src1_arf_id),
    .src2_arf_id         (src2_arf_id),
    .src1_renamed        (src1_renamed),
    .src1_rob_id         (src1_rob_id),
    .src1_reg_data       (src1_reg_data),
    .src2_renamed        (src2_renamed),
    .src2_rob_id         (src2_rob_id),
    .src2_reg_data       (src2_reg_data)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got no summary, expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus table ----------------
  typedef struct {
    logic      de, dv;
    arf_id_t   dd;
    rob_id_t   drob;
    logic      rt;
    arf_id_t   rarf;
    rob_id_t   rrob;
    reg_data_t rdata;
    logic      fl;
    arf_id_t   s1, s2;
    logic      strict;
    logic      r1;
    rob_id_t   t1;
    reg_data_t d1;
    logic      r2;
    rob_id_t   t2;
    reg_data_t d2;
  } vec_t;

  typedef struct packed {
    logic      strict;
    logic      r1;
    rob_id_t   t1;
    reg_data_t d1;
    logic      r2;
    rob_id_t   t2;
    reg_data_t d2;
  } exp_t;

  localparam int EXP_W = $bits(exp_t);

  vec_t vecs[$];
  logic [EXP_W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic add(input logic de, dv, input arf_id_t dd, input rob_id_t drob,
                     input logic rt, input arf_id_t rarf, input rob_id_t rrob,
                     input reg_data_t rdata, input logic fl,
                     input arf_id_t s1, s2, input logic strict,
                     input logic r1, input rob_id_t t1, input reg_data_t d1,
                     input logic r2, input rob_id_t t2, input reg_data_t d2);
    vec_t v;
    v.de = de; v.dv = dv; v.dd = dd; v.drob = drob;
    v.rt = rt; v.rarf = rarf; v.rrob = rrob; v.rdata = rdata; v.fl = fl;
    v.s1 = s1; v.s2 = s2; v.strict = strict;
    v.r1 = r1; v.t1 = t1; v.d1 = d1; v.r2 = r2; v.t2 = t2; v.d2 = d2;
    vecs.push_back(v);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    dispatch_en = 0; dispatch_dst_valid = 0; dispatch_dst_arf_id = '0; dispatch_rob_id = '0;
    retire = 0; retire_rob_id = '0; retire_arf_id = '0; retire_reg_data = '0;
    flush = 0; src1_arf_id = '0; src2_arf_id = '0;
  endtask

  task automatic push_exp(input logic strict, input logic r1, input rob_id_t t1,
                          input reg_data_t d1, input logic r2, input rob_id_t t2,
                          input reg_data_t d2);
    exp_t e;
    e.strict = strict; e.r1 = r1; e.t1 = t1; e.d1 = d1; e.r2 = r2; e.t2 = t2; e.d2 = d2;
    exp_q.push_back(EXP_W'(e));
  endtask

  // ---------------- scoreboard ----------------
  task automatic check_outputs(input string name);
    exp_t e;
    logic ok1, ok2;
    if (exp_q.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: no expected entry queued, got outputs, required one entry", name);
      return;
    end
    e = exp_t'(exp_q.pop_front());
    // ROB id is only meaningful while renamed, except where all-zero is required.
    ok1 = (src1_renamed == e.r1) && (src1_reg_data == e.d1) &&
          (!(e.strict || e.r1) || (src1_rob_id == e.t1));
    ok2 = (src2_renamed == e.r2) && (src2_reg_data == e.d2) &&
          (!(e.strict || e.r2) || (src2_rob_id == e.t2));
    n_cmp++;
    if (!ok1) begin
      n_bad++;
      $display("FAIL %s src1: got renamed=%0b rob=%0d data=%h, expected renamed=%0b rob=%0d data=%h",
               name, src1_renamed, src1_rob_id, src1_reg_data, e.r1, e.t1, e.d1);
    end
    n_cmp++;
    if (!ok2) begin
      n_bad++;
      $display("FAIL %s src2: got renamed=%0b rob=%0d data=%h, expected renamed=%0b rob=%0d data=%h",
               name, src2_renamed, src2_rob_id, src2_reg_data, e.r2, e.t2, e.d2);
    end
  endtask

  task automatic apply_vec(input vec_t v, input int idx);
    @(negedge clk);
    dispatch_en = v.de; dispatch_dst_valid = v.dv;
    dispatch_dst_arf_id = v.dd; dispatch_rob_id = v.drob;
    retire = v.rt; retire_arf_id = v.rarf; retire_rob_id = v.rrob; retire_reg_data = v.rdata;
    flush = v.fl; src1_arf_id = v.s1; src2_arf_id = v.s2;
    push_exp(v.strict, v.r1, v.t1, v.d1, v.r2, v.t2, v.d2);
    #1;
    check_outputs($sformatf("vec%0d", idx));
  endtask

  // ---------------- test ----------------
  initial begin
    drive_idle();
    rst_aL = 1'b0;

    //   de dv dd    drob rt rarf rrob rdata       fl s1    s2    st r1 t1 d1          r2 t2 d2
    add(0, 0, 5'd0,  0,   0, 5'd0, 0,  32'h0,      0, 5'd5, 5'd0, 1, 0, 0, 32'h0,      0, 0, 32'h0);
    add(1, 1, 5'd5,  3,   0, 5'd0, 0,  32'h0,      0, 5'd5, 5'd7, 0, 0, 0, 32'h0,      0, 0, 32'h0);
    add(0, 0, 5'd0,  0,   0, 5'd0, 0,  32'h0,      0, 5'd5, 5'd0, 0, 1, 3, 32'h0,      0, 0, 32'h0);
    add(0, 0, 5'd0,  0,   1, 5'd5, 3,  32'hDEAD,   0, 5'd6, 5'd5, 0, 0, 0, 32'h0,      0, 0, 32'hDEAD);
    add(0, 0, 5'd0,  0,   0, 5'd0, 0,  32'h0,      0, 5'd5, 5'd0, 0, 0, 0, 32'hDEAD,   0, 0, 32'h0);
    add(1, 1, 5'd7,  1,   0, 5'd0, 0,  32'h0,      0, 5'd7, 5'd0, 0, 0, 0, 32'h0,      0, 0, 32'h0);
    add(1, 1, 5'd7,  4,   0, 5'd0, 0,  32'h0,      0, 5'd7, 5'd0, 0, 1, 1, 32'h0,      0, 0, 32'h0);
    add(0, 0, 5'd0,  0,   1, 5'd7, 1,  32'h11,     0, 5'd7, 5'd7, 0, 1, 4, 32'h0,      1, 4, 32'h0);
    add(0, 0, 5'd0,  0,   0, 5'd0, 0,  32'h0,      0, 5'd7, 5'd0, 0, 1, 4, 32'h11,     0, 0, 32'h0);
    add(1, 1, 5'd9,  2,   0, 5'd0, 0,  32'h0,      0, 5'd9, 5'd0, 0, 0, 0, 32'h0,      0, 0, 32'h0);
    add(0, 0, 5'd0,  0,   1, 5'd9, 2,  32'h55,     0, 5'd9, 5'd9, 0, 0, 0, 32'h55,     0, 0, 32'h55);
    add(0, 0, 5'd0,  0,   0, 5'd0, 0,  32'h0,      0, 5'd9, 5'd0, 0, 0, 0, 32'h55,     0, 0, 32'h0);
    add(1, 1, 5'd3,  5,   0, 5'd0, 0,  32'h0,      0, 5'd3, 5'd0, 0, 0, 0, 32'h0,      0, 0, 32'h0);
    add(1, 1, 5'd3,  6,   1, 5'd3, 5,  32'h77,     0, 5'd3, 5'd3, 0, 0, 0, 32'h77,     0, 0, 32'h77);
    add(0, 0, 5'd0,  0,   0, 5'd0, 0,  32'h0,      0, 5'd3, 5'd0, 0, 1, 6, 32'h77,     0, 0, 32'h0);
    add(1, 1, 5'd1,  7,   0, 5'd0, 0,  32'h0,      0, 5'd1, 5'd0, 0, 0, 0, 32'h0,      0, 0, 32'h0);
    add(1, 1, 5'd2,  8,   0, 5'd0, 0,  32'h0,      0, 5'd1, 5'd0, 0, 1, 7, 32'h0,      0, 0, 32'h0);
    add(1, 1, 5'd4,  9,   0, 5'd0, 0,  32'h0,      1, 5'd1, 5'd2, 0, 1, 7, 32'h0,      1, 8, 32'h0);
    add(0, 0, 5'd0,  0,   0, 5'd0, 0,  32'h0,      0, 5'd1, 5'd2, 0, 0, 0, 32'h0,      0, 0, 32'h0);
    add(0, 0, 5'd0,  0,   0, 5'd0, 0,  32'h0,      0, 5'd4, 5'd3, 0, 0, 0, 32'h0,      0, 0, 32'h77);
    add(1, 1, 5'd0,  10,  1, 5'd0, 0,  32'hFF,     0, 5'd0, 5'd0, 1, 0, 0, 32'h0,      0, 0, 32'h0);
    add(0, 0, 5'd0,  0,   0, 5'd0, 0,  32'h0,      0, 5'd0, 5'd0, 1, 0, 0, 32'h0,      0, 0, 32'h0);
    add(1, 1, 5'd12, 11,  0, 5'd0, 0,  32'h0,      0, 5'd12, 5'd0, 0, 0, 0, 32'h0,     0, 0, 32'h0);
    add(0, 0, 5'd0,  0,   1, 5'd12, 11, 32'hABC,   1, 5'd12, 5'd12, 0, 0, 0, 32'hABC,  0, 0, 32'hABC);
    add(0, 0, 5'd0,  0,   0, 5'd0, 0,  32'h0,      0, 5'd12, 5'd0, 0, 0, 0, 32'hABC,   0, 0, 32'h0);
    add(0, 0, 5'd0,  0,   1, 5'd13, 2, 32'h13,     0, 5'd13, 5'd0, 0, 0, 0, 32'h0,     0, 0, 32'h0);
    add(0, 0, 5'd0,  0,   0, 5'd0, 0,  32'h0,      0, 5'd13, 5'd0, 0, 0, 0, 32'h13,    0, 0, 32'h0);
    add(1, 0, 5'd14, 3,   0, 5'd0, 0,  32'h0,      0, 5'd14, 5'd0, 0, 0, 0, 32'h0,     0, 0, 32'h0);
    add(0, 0, 5'd0,  0,   0, 5'd0, 0,  32'h0,      0, 5'd14, 5'd0, 0, 0, 0, 32'h0,     0, 0, 32'h0);
    add(1, 1, 5'd31, 15,  0, 5'd0, 0,  32'h0,      0, 5'd31, 5'd0, 0, 0, 0, 32'h0,     0, 0, 32'h0);
    add(0, 0, 5'd0,  0,   0, 5'd0, 0,  32'h0,      0, 5'd31, 5'd30, 0, 1, 15, 32'h0,   0, 0, 32'h0);

    repeat (2) @(negedge clk);
    rst_aL = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      apply_vec(vecs[i], i);
    end

    // Asynchronous reset asserted between edges, with live state.
    @(negedge clk);
    drive_idle();
    dispatch_en = 1; dispatch_dst_valid = 1; dispatch_dst_arf_id = 5'd20; dispatch_rob_id = 4'd12;
    @(negedge clk);
    drive_idle();
    retire = 1; retire_arf_id = 5'd21; retire_rob_id = 4'd0; retire_reg_data = 32'h2121;
    @(negedge clk);
    drive_idle();
    src1_arf_id = 5'd20; src2_arf_id = 5'd21;
    push_exp(0, 1, 12, 32'h0, 0, 0, 32'h2121);
    #1 check_outputs("pre_reset");
    #2 rst_aL = 1'b0;
    push_exp(1, 0, 0, 32'h0, 0, 0, 32'h0);
    #1 check_outputs("async_reset");

    // Updates held off while reset is low, then take effect on the first edge after release.
    @(negedge clk);
    dispatch_en = 1; dispatch_dst_valid = 1; dispatch_dst_arf_id = 5'd20; dispatch_rob_id = 4'd5;
    retire = 1; retire_arf_id = 5'd21; retire_rob_id = 4'd0; retire_reg_data = 32'h99;
    @(negedge clk);
    push_exp(1, 0, 0, 32'h0, 0, 0, 32'h0);
    #1 check_outputs("in_reset");
    rst_aL = 1'b1;
    @(negedge clk);
    retire = 0;
    push_exp(0, 1, 5, 32'h0, 0, 0, 32'h99);
    #1 check_outputs("after_release");
    drive_idle();

    if (exp_q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/arf_rat.md
ARF_RAT -- requirements
Module: arf_rat

Interface
REQ-001 SHALL have parameter ARF_N_ENTRIES, default 32, number of architectural integer registers (x0..x31).
REQ-002 SHALL have parameter ROB_N_ENTRIES, default from shared package, ROB depth; tag width is log2(ROB_N_ENTRIES).
REQ-003 SHALL have parameter REG_DATA_WIDTH, default 32, register data width.
REQ-004 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-005 SHALL have port rst_aL, input, 1, reset; asynchronous, active-low.
REQ-006 SHALL have port dispatch_en, input, 1, dispatch handshake fired (valid AND ROB ready) this cycle.
REQ-007 SHALL have port dispatch_dst_valid, input, 1, dispatched instruction writes a destination.
REQ-008 SHALL have port dispatch_dst_arf_id, input, arf_id_t, destination register.
REQ-009 SHALL have port dispatch_rob_id, input, rob_id_t, ROB slot allocated by the ROB.
REQ-010 SHALL have port retire, input, 1, ROB retires an entry with a destination this cycle.
REQ-011 SHALL have port retire_rob_id, input, rob_id_t, retiring ROB slot.
REQ-012 SHALL have port retire_arf_id, input, arf_id_t, retiring destination register.
REQ-013 SHALL have port retire_reg_data, input, reg_data_t, committed value.
REQ-014 SHALL have port flush, input, 1, pipeline flush; discard all speculative mappings.
REQ-015 SHALL have ports src1_arf_id / src2_arf_id, input, arf_id_t, operand lookup addresses.
REQ-016 SHALL have ports srcN_renamed, output, 1, operand pending in ROB (N=1,2).
REQ-017 SHALL have ports srcN_rob_id, output, rob_id_t, producing ROB slot, valid when srcN_renamed=1.
REQ-018 SHALL have ports srcN_reg_data, output, reg_data_t, committed value, valid when srcN_renamed=0.

Function
REQ-019 SHALL hold per register: data[REG_DATA_WIDTH], renamed bit, tag (rob_id_t).
REQ-020 SHALL treat x0 as constant: reads return renamed=0, data=0; dispatch/retire targeting x0 ignored.
REQ-021 SHALL on dispatch_en & dispatch_dst_valid & dst!=0 set renamed[dst]=1, tag[dst]=dispatch_rob_id at next edge.
REQ-022 SHALL on retire & retire_arf_id!=0 write data[id]=retire_reg_data at next edge, regardless of tag.
REQ-023 SHALL on retire clear renamed[id] only if tag[id]==retire_rob_id (no younger writer).
REQ-024 SHALL, when dispatch and retire target the same register in one cycle, write data and leave renamed=1 with tag=dispatch_rob_id (dispatch wins).
REQ-025 SHALL on flush clear all renamed bits at next edge; flush overrides same-cycle dispatch; same-cycle retire data write still occurs.
REQ-026 SHALL produce src outputs combinationally from current state (zero-cycle read).
REQ-027 SHALL bypass same-cycle retire: if retire & srcN_arf_id==retire_arf_id!=0 & renamed & tag==retire_rob_id, output renamed=0, data=retire_reg_data.
REQ-028 SHALL NOT bypass same-cycle dispatch to src reads (dispatch stage resolves intra-bundle dependences).
REQ-029 SHALL keep all state unchanged when no dispatch, retire or flush occurs.

Reset
REQ-030 SHALL on rst_aL=0 asynchronously clear all data, renamed and tag bits to 0; outputs therefore read renamed=0, rob_id=0, data=0.
REQ-031 SHALL ignore dispatch/retire/flush while rst_aL=0; first update occurs on first rising edge after deassertion.

Structure
REQ-032 SHALL take arf_id_t, rob_id_t, reg_data_t, ARF_N_ENTRIES, ROB_N_ENTRIES, REG_DATA_WIDTH from the shared global definitions header.
REQ-033 SHALL add rat_entry_t (renamed, tag) to the shared header for reuse by checkpoint logic.
REQ-034 SHALL instantiate one sub-module arf_rat_entry per register (holds data/renamed/tag, update logic); read mux and bypass remain in arf_rat.

Verification
REQ-035 SHALL test dispatch x5->rob 3, read x5 -> renamed=1, rob_id=3; retire x5 rob 3 data 0xDEAD -> next cycle renamed=0, data=0xDEAD.
REQ-036 SHALL test dispatch x7->rob 1 then x7->rob 4; retire rob 1 data 0x11 -> data=0x11, renamed=1, rob_id=4.
REQ-037 SHALL test same-cycle retire x9 rob 2 data 0x55 with src1=x9 -> src1_renamed=0, data=0x55 that cycle.
REQ-038 SHALL test same-cycle dispatch x3->rob 6 and retire x3 rob 5 (tag 5) data 0x77 -> data=0x77, renamed=1, rob_id=6.
REQ-039 SHALL test flush with x1,x2 renamed plus same-cycle dispatch x4 -> all renamed=0 next cycle; dispatch x0 and retire x0 data 0xFF -> x0 reads 0.
REQ-040 SHALL test rst_aL asserted mid-sequence off-edge -> all outputs 0 immediately.
